score_tx_framer: RTL and testbench
==================================

# score_tx_framer

Frame builder that sits directly upstream of the UART transmit path. On a SEND request it latches two 8-bit score values and emits a fixed frame, byte by byte, over the UART's DATA_IN / TRG_WRITE / DONE handshake: header 0xA5, SCORE_A, SCORE_B, and an optional XOR checksum. It paces bytes with a programmable inter-byte gap and aborts the frame if the UART never reports DONE.

## Interface
- TRG_CYCLES, 5: width of the TRG_WRITE pulse in clocks (100 ns at 50 MHz).
- GAP_CYCLES, 16: idle clocks between a byte's DONE and the next TRG_WRITE; 0 is legal.
- TIMEOUT_CYCLES, 1000000: maximum clocks spent waiting for DONE per byte (20 ms).
- CLK_50MHZ  in  1  system clock; one clock domain.
- RST  in  1  reset, asynchronous, active-high.
- SEND  in  1  frame request; sampled only in IDLE.
- SCORE_A  in  8  first score; latched on an accepted SEND.
- SCORE_B  in  8  second score; latched on an accepted SEND.
- DONE  in  1  UART byte-complete, one-cycle pulse.
- DATA_IN  out  8  byte to the UART.
- TRG_WRITE  out  1  UART write strobe.
- BUSY  out  1  frame in progress.
- SENT  out  1  one-cycle pulse: frame completed.
- ERR  out  1  one-cycle pulse: frame aborted on timeout.

## Operation
- States:
  - IDLE: wait for a request.
  - TRIG: drive TRG_WRITE for TRG_CYCLES.
  - WAIT_DONE: wait for the UART to finish the byte.
  - GAP: pace the next byte.
  - FINISH: close the frame.
- Byte index idx selects DATA_IN:
  - 0: 0xA5
  - 1: SCORE_A latched
  - 2: SCORE_B latched
  - 3: checksum, present only when the checksum is enabled.
- Frame length is 4 bytes with the checksum, 3 without.
- IDLE → TRIG on SEND=1:
  - latch both scores;
  - set idx=0;
  - assert BUSY.
- TRIG → WAIT_DONE after exactly TRG_CYCLES cycles with TRG_WRITE=1.
- WAIT_DONE → GAP on DONE when idx is not the last byte.
- WAIT_DONE → FINISH on DONE when idx is the last byte.
- GAP → TRIG after GAP_CYCLES cycles, with idx+1. When GAP_CYCLES=0, pass straight through to TRIG.
- FINISH → IDLE, with a SENT pulse.
- Timeout: if the timeout counter reaches TIMEOUT_CYCLES in WAIT_DONE:
  - pulse ERR;
  - go to IDLE;
  - drop the rest of the frame.
- The timeout counter restarts on each entry to TRIG.
- A DONE pulse during TRIG is latched into a pending flag and consumed on entry to WAIT_DONE. A DONE in IDLE or GAP is ignored.
- SEND outside IDLE is ignored; requests are not queued. Score inputs may change freely while BUSY.
- Checksum: 8-bit XOR of header, SCORE_A and SCORE_B.

## Timing
- Reset values:
  - DATA_IN=0x00
  - TRG_WRITE=0
  - BUSY=0
  - SENT=0
  - ERR=0
  - state IDLE
  - all counters 0
  - pending flag 0
- Reset mid-frame aborts at once. No SENT or ERR is issued, and the frame does not resume after reset.
- SEND high at cycle 0:
  - TRG_WRITE and BUSY are high from cycle 1;
  - DATA_IN is valid from cycle 1;
  - TRG_WRITE falls at cycle 1+TRG_CYCLES.
- DATA_IN is registered and held stable from the first TRG_WRITE cycle until the next byte is loaded.
- DONE at cycle d, not last byte: the next TRG_WRITE rises at cycle d+1+GAP_CYCLES.
- DONE at cycle d, last byte:
  - SENT=1 at cycle d+1 only;
  - BUSY falls at cycle d+2;
  - a new SEND is accepted at d+2.
- All outputs are registered; no combinational path from input to output.

## Configuration
- Macro SCORE_TX_CHECKSUM_EN.
- Defined: 4-byte frame including the XOR checksum byte.
- Undefined: 3-byte frame; the checksum logic is compiled out entirely.

## Structure
- Package score_tx_pkg holds:
  - the state enum;
  - HDR_BYTE = 8'hA5;
  - the LAST_IDX constant, derived from SCORE_TX_CHECKSUM_EN.
- One sub-module, score_tx_timer:
  - loadable down-counter with a zero flag;
  - width $clog2(TIMEOUT_CYCLES+1);
  - one shared instance serves the trigger-width, gap and timeout counts.

## Test plan
- Reset, then SEND with A=0x03, B=0x06, and the bench UART model answering each byte with DONE 50 cycles after TRG_WRITE falls:
  - checksum enabled: DATA_IN sequence A5, 03, 06, A0;
  - checksum disabled: A5, 03, 06;
  - SENT pulses once.
- Check the TRG_WRITE high time is exactly 5 cycles, and the gap from DONE to the next TRG_WRITE rise is 17 cycles.
- SEND held high continuously for 3 frames → exactly one frame per IDLE entry. A second SEND pulse while BUSY is ignored.
- Bench withholds DONE on byte 1 → ERR pulses once TIMEOUT_CYCLES is reached (shortened parameter, 200), no SENT, BUSY low afterwards.
- Assert RST during WAIT_DONE of byte 2 → all outputs return to reset values at once. A fresh SEND then sends a full frame from the header.
- DONE pulsed during the TRIG phase → it is honoured, with no timeout.

Source files
------------

// File: rtl/score_tx_pkg.sv
// Shared types and constants for the score frame transmitter.
// SCORE_TX_CHECKSUM_EN selects the 4-byte frame that carries the XOR checksum.
package score_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_DONE,
    S_GAP,
    S_FINISH
  } state_e;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

`ifdef SCORE_TX_CHECKSUM_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  // Frame byte for a given index, built from the latched scores.
  function automatic logic [7:0] byte_sel(input logic [1:0] idx,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
    logic [7:0] r;
    case (idx)
      2'd0:    r = HDR_BYTE;
      2'd1:    r = a;
      2'd2:    r = b;
`ifdef SCORE_TX_CHECKSUM_EN
      default: r = HDR_BYTE ^ a ^ b;
`else
      default: r = 8'h00;
`endif
    endcase
    return r;
  endfunction

endpackage

// File: rtl/score_tx_timer.sv
// Loadable down-counter with a zero flag; one instance times the trigger
// width, the inter-byte gap and the DONE timeout in turn.
module score_tx_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/score_tx_framer.sv
// Builds the A5 / SCORE_A / SCORE_B [/ checksum] frame over the UART write handshake.
// Define SCORE_TX_CHECKSUM_EN to append the XOR checksum byte.
module score_tx_framer
  import score_tx_pkg::*;
#(
  parameter int TRG_CYCLES     = 5,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       SEND,
  input  logic [7:0] SCORE_A,
  input  logic [7:0] SCORE_B,
  input  logic       DONE,
  output logic [7:0] DATA_IN,
  output logic       TRG_WRITE,
  output logic       BUSY,
  output logic       SENT,
  output logic       ERR
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // Timer reads zero on the last cycle of each phase, so load count-1.
  localparam logic [TW-1:0] TRG_LD = TW'(TRG_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TO_LD  = TW'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d, idx_nx;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [7:0]  data_q, data_d;
  logic        trg_q, trg_d;
  logic        busy_q, busy_d;
  logic        sent_q, sent_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;
  logic          tmr_load, tmr_zero;
  logic [TW-1:0] tmr_val;

  score_tx_timer #(.W(TW)) u_timer (
    .clk      (CLK_50MHZ),
    .rst      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    idx_nx   = idx_q + 2'd1;
    a_d      = a_q;
    b_d      = b_q;
    data_d   = data_q;
    trg_d    = trg_q;
    busy_d   = busy_q;
    sent_d   = 1'b0;
    err_d    = 1'b0;
    pend_d   = pend_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      S_IDLE: begin
        pend_d = 1'b0;
        if (SEND) begin
          a_d      = SCORE_A;
          b_d      = SCORE_B;
          idx_d    = 2'd0;
          data_d   = HDR_BYTE;
          trg_d    = 1'b1;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TRG_LD;
          state_d  = S_TRIG;
        end
      end
      S_TRIG: begin
        if (DONE) pend_d = 1'b1;
        if (tmr_zero) begin
          trg_d    = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = TO_LD;
          state_d  = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (DONE || pend_q) begin
          pend_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            sent_d  = 1'b1;
            state_d = S_FINISH;
          end else if (GAP_CYCLES == 0) begin
            idx_d    = idx_nx;
            data_d   = byte_sel(idx_nx, a_q, b_q);
            trg_d    = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = TRG_LD;
            state_d  = S_TRIG;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
            state_d  = S_GAP;
          end
        end else if (tmr_zero) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (tmr_zero) begin
          idx_d    = idx_nx;
          data_d   = byte_sel(idx_nx, a_q, b_q);
          trg_d    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TRG_LD;
          state_d  = S_TRIG;
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      data_q  <= 8'h00;
      trg_q   <= 1'b0;
      busy_q  <= 1'b0;
      sent_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      trg_q   <= trg_d;
      busy_q  <= busy_d;
      sent_q  <= sent_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  assign DATA_IN   = data_q;
  assign TRG_WRITE = trg_q;
  assign BUSY      = busy_q;
  assign SENT      = sent_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_score_tx_framer.sv
// Directed/randomized bench for score_tx_framer with an inline UART responder
// and a frame model built from the header, scores and their XOR.
module tb_score_tx_framer;

  localparam int TRG = 5;
  localparam int GAP = 16;
  localparam int TO  = 200;

  logic       CLK_50MHZ = 1'b0;
  logic       RST, SEND, DONE;
  logic [7:0] SCORE_A, SCORE_B;
  logic [7:0] DATA_IN;
  logic       TRG_WRITE, BUSY, SENT, ERR;

  int checks = 0, errors = 0;
  int sent_cnt = 0, err_cnt = 0;

  score_tx_framer #(.TRG_CYCLES(TRG), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .CLK_50MHZ (CLK_50MHZ),
    .RST       (RST),
    .SEND      (SEND),
    .SCORE_A   (SCORE_A),
    .SCORE_B   (SCORE_B),
    .DONE      (DONE),
    .DATA_IN   (DATA_IN),
    .TRG_WRITE (TRG_WRITE),
    .BUSY      (BUSY),
    .SENT      (SENT),
    .ERR       (ERR)
  );

  always #5 CLK_50MHZ = ~CLK_50MHZ;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_50MHZ);
    #1;
    if (SENT === 1'b1) sent_cnt++;
    if (ERR === 1'b1)  err_cnt++;
  endtask

  // Entered on the first TRG_WRITE cycle of a frame. stop_idx selects a byte on
  // which DONE is withheld: it then times out, or RST is applied if stop_rst.
  task automatic frame(input logic [7:0] a, input logic [7:0] b, input int stop_idx,
                       input bit stop_rst, input bit trig_done, input bit hold);
    logic [7:0] exp_q[$];
    int n, s0, e0;
    exp_q = {8'hA5, a, b};
`ifdef SCORE_TX_CHECKSUM_EN
    exp_q.push_back(8'hA5 ^ a ^ b);
`endif
    s0 = sent_cnt;
    e0 = err_cnt;
    chk("first_trg", TRG_WRITE, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("data", DATA_IN, exp_q[i]);
      chk("busy", BUSY, 1);
      if (i == 0) begin
        SCORE_A = 8'($urandom);
        SCORE_B = 8'($urandom);
      end
      n = 0;
      while (TRG_WRITE === 1'b1 && n < 50) begin
        DONE = trig_done && (n == 1);
        n++;
        tick();
      end
      DONE = 1'b0;
      chk("trg_width", n, TRG);
      chk("data_hold", DATA_IN, exp_q[i]);
      if (i == stop_idx && !stop_rst) begin
        n = 0;
        while (ERR !== 1'b1 && n < TO + 50) begin
          n++;
          tick();
        end
        chk("timeout_window", (n >= TO - 1 && n <= TO + 1), 1);
        chk("timeout_busy", BUSY, 0);
        tick();
        chk("err_pulse", ERR, 0);
        chk("err_once", err_cnt - e0, 1);
        chk("no_sent_on_err", sent_cnt - s0, 0);
        return;
      end
      if (i == stop_idx && stop_rst) begin
        repeat (10) tick();
        #2 RST = 1'b1;
        #1 chk("rst_outs", {DATA_IN, TRG_WRITE, BUSY, SENT, ERR}, 0);
        tick();
        tick();
        RST = 1'b0;
        repeat (5) tick();
        chk("rst_idle", {TRG_WRITE, BUSY}, 0);
        chk("rst_no_sent", sent_cnt - s0, 0);
        chk("rst_no_err", err_cnt - e0, 0);
        return;
      end
      if (trig_done) tick();
      else begin
        repeat (50) tick();
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
      end
      if (i == exp_q.size() - 1) begin
        chk("sent_pulse", SENT, 1);
        chk("busy_at_sent", BUSY, 1);
        tick();
        chk("sent_end", SENT, 0);
        chk("busy_fall", BUSY, 0);
        chk("sent_once", sent_cnt - s0, 1);
        chk("no_err", err_cnt - e0, 0);
      end else begin
        n = 0;
        while (TRG_WRITE !== 1'b1 && n < 100) begin
          SEND = hold | (i == 0 && n == 3);
          n++;
          tick();
        end
        SEND = hold;
        chk("gap", n + 1, GAP + 1);
      end
    end
  endtask

  initial begin
    logic [7:0] a, b;
    RST = 1'b1; SEND = 1'b0; DONE = 1'b0; SCORE_A = 8'h00; SCORE_B = 8'h00;
    repeat (3) tick();
    chk("reset_outs", {DATA_IN, TRG_WRITE, BUSY, SENT, ERR}, 0);
    RST = 1'b0;
    tick();
    chk("post_reset_idle", {TRG_WRITE, BUSY}, 0);

    SCORE_A = 8'h03; SCORE_B = 8'h06; SEND = 1'b1; tick(); SEND = 1'b0;
    frame(8'h03, 8'h06, -1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("stray_send_dropped", BUSY, 0);

    for (int k = 0; k < 3; k++) begin
      a = 8'($urandom); b = 8'($urandom);
      SCORE_A = a; SCORE_B = b; SEND = 1'b1; tick(); SEND = 1'b0;
      frame(a, b, -1, 1'b0, 1'b0, 1'b0);
      repeat (2 + $urandom_range(0, 4)) tick();
    end

    a = 8'($urandom); b = 8'($urandom);
    SCORE_A = a; SCORE_B = b; SEND = 1'b1; tick(); SEND = 1'b0;
    frame(a, b, -1, 1'b0, 1'b1, 1'b0);
    tick();

    a = 8'($urandom); b = 8'($urandom);
    SCORE_A = a; SCORE_B = b; SEND = 1'b1; tick();
    for (int k = 0; k < 3; k++) begin
      frame(a, b, -1, 1'b0, 1'b0, 1'b1);
      a = SCORE_A; b = SCORE_B;
      if (k < 2) tick();
      else SEND = 1'b0;
    end
    tick();
    tick();
    chk("hold_three_only", BUSY, 0);

    a = 8'($urandom); b = 8'($urandom);
    SCORE_A = a; SCORE_B = b; SEND = 1'b1; tick(); SEND = 1'b0;
    frame(a, b, 1, 1'b0, 1'b0, 1'b0);
    tick();

    a = 8'($urandom); b = 8'($urandom);
    SCORE_A = a; SCORE_B = b; SEND = 1'b1; tick(); SEND = 1'b0;
    frame(a, b, 2, 1'b1, 1'b0, 1'b0);

    a = 8'($urandom); b = 8'($urandom);
    SCORE_A = a; SCORE_B = b; SEND = 1'b1; tick(); SEND = 1'b0;
    frame(a, b, -1, 1'b0, 1'b0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
